// File: rtl/reg_file_wb_sink_pkg.sv
// reg_file_wb_sink_pkg: shared register-file widths, zero-register constant and word/address types
package reg_file_wb_sink_pkg;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DEPTH  = 32;
    localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;
    typedef logic [RF_ADDR_W-1:0] reg_addr_t;
    typedef logic [RF_DATA_W-1:0] word_t;
endpackage

// File: rtl/reg_file_wb_sink_if.sv
// reg_file_wb_sink_if: write-back inputs and the two ID-stage read ports of the register file
interface reg_file_wb_sink_if
    import reg_file_wb_sink_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
);
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              reg_write;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    modport master (
        output write_reg, write_data, reg_write, read_reg1, read_reg2,
        input  read_data1, read_data2
    );
    modport slave (
        input  write_reg, write_data, reg_write, read_reg1, read_reg2,
        output read_data1, read_data2
    );
endinterface

// File: rtl/reg_file_wb_sink_rf_read_port.sv
// rf_read_port: one asynchronous read port with zero-register forcing;
// REGFILE_BYPASS_EN adds same-cycle write-through from the WB stage.
module rf_read_port
    import reg_file_wb_sink_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic [DATA_W-1:0] entries [2**ADDR_W],
    input  logic [ADDR_W-1:0] read_reg,
`ifdef REGFILE_BYPASS_EN
    input  logic              rst_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
`endif
    output logic [DATA_W-1:0] read_data
);
`ifdef REGFILE_BYPASS_EN
    // read_reg != 0 already implies write_reg != 0 on a match
    always_comb read_data = (read_reg == REG_ZERO) ? '0 :
                            (rst_n && reg_write && read_reg == write_reg) ? write_data :
                            entries[read_reg];
`else
    always_comb read_data = (read_reg == REG_ZERO) ? '0 : entries[read_reg];
`endif
endmodule

// File: rtl/reg_file_wb_sink.sv
// reg_file_wb_sink: 32-entry register file fed by the WB stage, two async read ports;
// optional write-to-read bypass under REGFILE_BYPASS_EN.
module reg_file_wb_sink
    import reg_file_wb_sink_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input logic i_clk,
    input logic i_rst_n,
    reg_file_wb_sink_if.slave wb
);
    logic [DATA_W-1:0] regs [2**ADDR_W];
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
        else if (wb.reg_write && wb.write_reg != REG_ZERO)
            regs[wb.write_reg] <= wb.write_data;
    end
    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port1 (
        .entries(regs),
        .read_reg(wb.read_reg1),
`ifdef REGFILE_BYPASS_EN
        .rst_n(i_rst_n),
        .reg_write(wb.reg_write),
        .write_reg(wb.write_reg),
        .write_data(wb.write_data),
`endif
        .read_data(wb.read_data1)
    );
    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port2 (
        .entries(regs),
        .read_reg(wb.read_reg2),
`ifdef REGFILE_BYPASS_EN
        .rst_n(i_rst_n),
        .reg_write(wb.reg_write),
        .write_reg(wb.write_reg),
        .write_data(wb.write_data),
`endif
        .read_data(wb.read_data2)
    );
endmodule

// File: tb/tb_reg_file_wb_sink.sv
// tb_reg_file_wb_sink: directed plus random stimulus against an array model, scoreboard-checked read ports
module tb_reg_file_wb_sink;
    import reg_file_wb_sink_pkg::*;
    typedef struct {
        string     name;
        reg_addr_t a1;
        reg_addr_t a2;
        word_t     e1;
        word_t     e2;
    } exp_t;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    reg_file_wb_sink_if bus ();
    reg_file_wb_sink dut (.i_clk(clk), .i_rst_n(rst_n), .wb(bus));
    word_t model [RF_DEPTH];
    exp_t  sb [$];
    int    checks = 0;
    int    errors = 0;

    function automatic word_t ref_rd(reg_addr_t a, logic r, logic we, reg_addr_t wa, word_t wd);
        if (a == REG_ZERO) return '0;
        if (BYP && r && we && wa == a) return wd;
        return model[a];
    endfunction

    function automatic reg_addr_t rnd_addr();
        if ($urandom_range(0, 1) == 1) return reg_addr_t'($urandom_range(0, 31));
        return reg_addr_t'($urandom_range(0, 3));
    endfunction

    task automatic step(string name, logic r, logic we, reg_addr_t wa, word_t wd,
                        reg_addr_t a1, reg_addr_t a2, bit chk = 1'b1);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        bus.reg_write = we;
        bus.write_reg = wa;
        bus.write_data = wd;
        bus.read_reg1 = a1;
        bus.read_reg2 = a2;
        if (chk) begin
            e.name = name;
            e.a1 = a1;
            e.a2 = a2;
            e.e1 = ref_rd(a1, r, we, wa, wd);
            e.e2 = ref_rd(a2, r, we, wa, wd);
            sb.push_back(e);
        end
        if (!r) begin
            for (int i = 0; i < RF_DEPTH; i++) model[i] = '0;
        end else if (we && wa != REG_ZERO) begin
            model[wa] = wd;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks += 2;
            if (bus.read_data1 !== e.e1) begin
                errors++;
                $display("FAIL %s port1 addr=%0d got=%h exp=%h", e.name, e.a1, bus.read_data1, e.e1);
            end
            if (bus.read_data2 !== e.e2) begin
                errors++;
                $display("FAIL %s port2 addr=%0d got=%h exp=%h", e.name, e.a2, bus.read_data2, e.e2);
            end
        end
    end

    initial begin
        bus.reg_write = 1'b0;
        bus.write_reg = '0;
        bus.write_data = '0;
        bus.read_reg1 = '0;
        bus.read_reg2 = '0;
        for (int i = 0; i < RF_DEPTH; i++) model[i] = '0;
        step("init", 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        step("w_r5", 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd7);
        step("rst_drop", 1'b0, 1'b1, 5'd7, 32'h0000_1234, 5'd5, 5'd7);
        step("post_rst", 1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
        for (int i = 0; i < RF_DEPTH; i++)
            step("rst_all", 1'b1, 1'b0, 5'd0, 32'h0, reg_addr_t'(i), reg_addr_t'(31 - i));
        step("w_r3", 1'b1, 1'b1, 5'd3, 32'hA5A5_0001, 5'd3, 5'd31);
        step("w_r31", 1'b1, 1'b1, 5'd31, 32'h0000_00FF, 5'd3, 5'd31);
        step("rd_3_31", 1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd31);
        step("w_r0", 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        step("rd_r0", 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        step("w_r9", 1'b1, 1'b1, 5'd9, 32'h0000_0042, 5'd0, 5'd0);
        step("we0_r9", 1'b1, 1'b0, 5'd9, 32'h1111_1111, 5'd9, 5'd9);
        step("rd_r9", 1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        step("w_r10", 1'b1, 1'b1, 5'd10, 32'h10, 5'd0, 5'd0);
        step("haz_r10", 1'b1, 1'b1, 5'd10, 32'h20, 5'd10, 5'd3);
        step("rd_r10", 1'b1, 1'b0, 5'd0, 32'h0, 5'd10, 5'd10);
        step("w_r12", 1'b1, 1'b1, 5'd12, 32'hCAFE_F00D, 5'd0, 5'd0);
        step("dual_r12", 1'b1, 1'b1, 5'd13, 32'h7777_1313, 5'd12, 5'd12);
        step("rd_12_13", 1'b1, 1'b0, 5'd0, 32'h0, 5'd12, 5'd13);
        repeat (400)
            step("rand", logic'($urandom_range(0, 39) != 0), logic'($urandom_range(0, 1)),
                 rnd_addr(), word_t'($urandom), rnd_addr(), rnd_addr());
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
